// File: rtl/scoreboard_ctrl_pkg.sv
// ============================================================================
// scoreboard_ctrl_pkg : shared types and encodings for the issue scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

package scoreboard_ctrl_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 2;

  typedef logic [1:0] class_t;
  localparam class_t CLASS_ALU  = 2'd0;
  localparam class_t CLASS_LOAD = 2'd1;
  localparam class_t CLASS_MD   = 2'd2;
  localparam class_t CLASS_RSVD = 2'd3;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic       dec_valid;
    logic [4:0] dec_raddr1;
    logic       dec_rden1;
    logic [4:0] dec_raddr2;
    logic       dec_rden2;
    logic [4:0] dec_waddr;
    logic       dec_wren;
    class_t     dec_class;
    logic       flush;
    logic       ld_done;
    logic [4:0] ld_waddr;
    logic       md_done;
    logic [4:0] md_waddr;
  } scoreboard_ctrl_in_type;

  typedef struct packed {
    logic             stall;
    logic             issue;
    logic             md_start;
    logic [NREGS-1:0] busy_mask;
    logic             err;
  } scoreboard_ctrl_out_type;

endpackage

`default_nettype wire

// File: rtl/scoreboard_ctrl_hazard_check.sv
// ============================================================================
// scoreboard_ctrl_hazard_check : RAW/WAW/structural detection from registered state
// Revision: 1.0
// ============================================================================
`default_nettype none

module scoreboard_ctrl_hazard_check
  import scoreboard_ctrl_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 2
) (
  input  logic [NREGS-1:0] busy_i,
  input  logic [CNT_W-1:0] ld_cnt_i,
  input  md_state_e        md_state_i,
  input  logic [4:0]       raddr1_i,
  input  logic             rden1_i,
  input  logic [4:0]       raddr2_i,
  input  logic             rden2_i,
  input  logic [4:0]       waddr_i,
  input  logic             wren_i,
  input  class_t           class_i,
  output logic             hazard_o
);

  logic raw1, raw2, waw, struct_ld, struct_md;

  // x0 is excluded explicitly so a stray busy[0] can never create a hazard
  assign raw1      = rden1_i & (raddr1_i != 5'd0) & busy_i[raddr1_i];
  assign raw2      = rden2_i & (raddr2_i != 5'd0) & busy_i[raddr2_i];
  assign waw       = wren_i  & (waddr_i  != 5'd0) & busy_i[waddr_i];
  assign struct_ld = (class_i == CLASS_LOAD) & (ld_cnt_i == CNT_W'(LD_DEPTH));
  assign struct_md = (class_i == CLASS_MD) & (md_state_i == MD_BUSY);

  assign hazard_o = raw1 | raw2 | waw | struct_ld | struct_md;

endmodule

`default_nettype wire

// File: rtl/scoreboard_ctrl.sv
// ============================================================================
// scoreboard_ctrl : long-latency writeback scoreboard and mul/div arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid_i,
  input  logic [4:0]       dec_raddr1_i,
  input  logic [4:0]       dec_raddr2_i,
  input  logic             dec_rden1_i,
  input  logic             dec_rden2_i,
  input  logic [4:0]       dec_waddr_i,
  input  logic             dec_wren_i,
  input  logic [1:0]       dec_class_i,
  input  logic             flush_i,
  input  logic             ld_done_i,
  input  logic [4:0]       ld_waddr_i,
  input  logic             md_done_i,
  input  logic [4:0]       md_waddr_i,
  output logic             stall_o,
  output logic             issue_o,
  output logic             md_start_o,
  output logic [NREGS-1:0] busy_mask_o,
  output logic             err_o
);

  scoreboard_ctrl_in_type  in_s;
  scoreboard_ctrl_out_type out_s;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  md_state_e        md_state_q, md_state_d;
  logic             err_q, err_d;
  logic             hazard, live, ld_issue, md_issue, ld_dec;

  assign in_s = '{dec_valid: dec_valid_i, dec_raddr1: dec_raddr1_i, dec_rden1: dec_rden1_i,
                  dec_raddr2: dec_raddr2_i, dec_rden2: dec_rden2_i, dec_waddr: dec_waddr_i,
                  dec_wren: dec_wren_i, dec_class: dec_class_i, flush: flush_i,
                  ld_done: ld_done_i, ld_waddr: ld_waddr_i, md_done: md_done_i,
                  md_waddr: md_waddr_i};

  scoreboard_ctrl_hazard_check #(.LD_DEPTH(LD_DEPTH)) u_hazard (
    .busy_i     (busy_q),
    .ld_cnt_i   (ld_cnt_q),
    .md_state_i (md_state_q),
    .raddr1_i   (in_s.dec_raddr1),
    .rden1_i    (in_s.dec_rden1),
    .raddr2_i   (in_s.dec_raddr2),
    .rden2_i    (in_s.dec_rden2),
    .waddr_i    (in_s.dec_waddr),
    .wren_i     (in_s.dec_wren),
    .class_i    (in_s.dec_class),
    .hazard_o   (hazard)
  );

  assign live     = in_s.dec_valid & ~in_s.flush;
  assign ld_issue = live & ~hazard & (in_s.dec_class == CLASS_LOAD);
  assign md_issue = live & ~hazard & (in_s.dec_class == CLASS_MD);

  always_comb begin
    busy_d     = busy_q;
    ld_cnt_d   = ld_cnt_q;
    md_state_d = md_state_q;
    err_d      = err_q;
    ld_dec     = 1'b0;

    // Completions to x0 are legal no-ops (loads with rd=x0 still occupy a slot)
    if (in_s.ld_done) begin
      if (ld_cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        ld_dec = 1'b1;
        if (in_s.ld_waddr != 5'd0) begin
          if (!busy_q[in_s.ld_waddr]) err_d = 1'b1;
          else                        busy_d[in_s.ld_waddr] = 1'b0;
        end
      end
    end

    if (in_s.md_done) begin
      if (md_state_q == MD_IDLE) begin
        err_d = 1'b1;
      end else begin
        md_state_d = MD_IDLE;
        if (in_s.md_waddr != 5'd0) begin
          if (!busy_q[in_s.md_waddr]) err_d = 1'b1;
          else                        busy_d[in_s.md_waddr] = 1'b0;
        end
      end
    end

    ld_cnt_d = ld_cnt_q + CNT_W'(ld_issue) - CNT_W'(ld_dec);
    if (md_issue) md_state_d = MD_BUSY;

    // Applied after the clears so a forced set/clear collision leaves the bit set
    if ((ld_issue | md_issue) & in_s.dec_wren & (in_s.dec_waddr != 5'd0))
      busy_d[in_s.dec_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ld_cnt_q   <= '0;
      md_state_q <= MD_IDLE;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      ld_cnt_q   <= ld_cnt_d;
      md_state_q <= md_state_d;
      err_q      <= err_d;
    end
  end

  assign out_s.stall     = live & hazard;
  assign out_s.issue     = live & ~hazard;
  assign out_s.md_start  = md_issue;
  assign out_s.busy_mask = busy_q;
  assign out_s.err       = err_q;

  assign stall_o     = out_s.stall;
  assign issue_o     = out_s.issue;
  assign md_start_o  = out_s.md_start;
  assign busy_mask_o = out_s.busy_mask;
  assign err_o       = out_s.err;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_ctrl.sv
// ============================================================================
// tb_scoreboard_ctrl : directed table-driven bench for scoreboard_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scoreboard_ctrl;

  typedef struct {
    logic        v;
    logic [4:0]  ra1;
    logic        re1;
    logic [4:0]  ra2;
    logic        re2;
    logic [4:0]  wa;
    logic        we;
    logic [1:0]  cls;
    logic        fl;
    logic        ldd;
    logic [4:0]  ldwa;
    logic        mdd;
    logic [4:0]  mdwa;
    logic        es;
    logic        ei;
    logic        em;
    logic [31:0] eb;
    logic        ee;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid, dec_rden1, dec_rden2, dec_wren, flush, ld_done, md_done;
  logic [4:0]  dec_raddr1, dec_raddr2, dec_waddr, ld_waddr, md_waddr;
  logic [1:0]  dec_class;
  logic        stall, issue, md_start, err;
  logic [31:0] busy_mask;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  scoreboard_ctrl #(.LD_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dec_valid_i  (dec_valid),
    .dec_raddr1_i (dec_raddr1),
    .dec_raddr2_i (dec_raddr2),
    .dec_rden1_i  (dec_rden1),
    .dec_rden2_i  (dec_rden2),
    .dec_waddr_i  (dec_waddr),
    .dec_wren_i   (dec_wren),
    .dec_class_i  (dec_class),
    .flush_i      (flush),
    .ld_done_i    (ld_done),
    .ld_waddr_i   (ld_waddr),
    .md_done_i    (md_done),
    .md_waddr_i   (md_waddr),
    .stall_o      (stall),
    .issue_o      (issue),
    .md_start_o   (md_start),
    .busy_mask_o  (busy_mask),
    .err_o        (err)
  );

  function automatic vec_t mk(logic v, logic [4:0] ra1, logic re1, logic [4:0] ra2, logic re2,
                              logic [4:0] wa, logic we, logic [1:0] cls, logic fl,
                              logic ldd, logic [4:0] ldwa, logic mdd, logic [4:0] mdwa,
                              logic es, logic ei, logic em, logic [31:0] eb, logic ee);
    vec_t t;
    t.v = v; t.ra1 = ra1; t.re1 = re1; t.ra2 = ra2; t.re2 = re2; t.wa = wa; t.we = we;
    t.cls = cls; t.fl = fl; t.ldd = ldd; t.ldwa = ldwa; t.mdd = mdd; t.mdwa = mdwa;
    t.es = es; t.ei = ei; t.em = em; t.eb = eb; t.ee = ee;
    return t;
  endfunction

  task automatic drive(vec_t t);
    dec_valid = t.v;  dec_raddr1 = t.ra1; dec_rden1 = t.re1; dec_raddr2 = t.ra2;
    dec_rden2 = t.re2; dec_waddr = t.wa;  dec_wren = t.we;   dec_class = t.cls;
    flush = t.fl; ld_done = t.ldd; ld_waddr = t.ldwa; md_done = t.mdd; md_waddr = t.mdwa;
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(vec_t t, int idx);
    chk("stall", idx, {31'd0, stall}, {31'd0, t.es});
    chk("issue", idx, {31'd0, issue}, {31'd0, t.ei});
    chk("md_start", idx, {31'd0, md_start}, {31'd0, t.em});
    chk("busy_mask", idx, busy_mask, t.eb);
    chk("err", idx, {31'd0, err}, {31'd0, t.ee});
  endtask

  initial begin
    // columns: v ra1 re1 ra2 re2 wa we cls fl ldd ldwa mdd mdwa | stall issue md_start busy err
    // load x5, dependent add stalls until the cycle after ld_done
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    0)); // 0
    tbl.push_back(mk(1, 0,0, 0,0, 5,1, 1, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 1
    tbl.push_back(mk(1, 5,1, 1,1, 6,1, 0, 0, 0,0,  0,0, 1,0,0, 32'h20,   0)); // 2
    tbl.push_back(mk(1, 5,1, 1,1, 6,1, 0, 0, 0,0,  0,0, 1,0,0, 32'h20,   0)); // 3
    tbl.push_back(mk(1, 5,1, 1,1, 6,1, 0, 0, 1,5,  0,0, 1,0,0, 32'h20,   0)); // 4
    tbl.push_back(mk(1, 5,1, 1,1, 6,1, 0, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 5
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    0)); // 6
    // three independent loads, depth 2
    tbl.push_back(mk(1, 0,0, 0,0, 10,1,1, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 7
    tbl.push_back(mk(1, 0,0, 0,0, 11,1,1, 0, 0,0,  0,0, 0,1,0, 32'h400,  0)); // 8
    tbl.push_back(mk(1, 0,0, 0,0, 12,1,1, 0, 0,0,  0,0, 1,0,0, 32'hC00,  0)); // 9
    tbl.push_back(mk(1, 0,0, 0,0, 12,1,1, 0, 1,10, 0,0, 1,0,0, 32'hC00,  0)); // 10
    tbl.push_back(mk(1, 0,0, 0,0, 12,1,1, 0, 0,0,  0,0, 0,1,0, 32'h800,  0)); // 11
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,11, 0,0, 0,0,0, 32'h1800, 0)); // 12
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,12, 0,0, 0,0,0, 32'h1000, 0)); // 13
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    0)); // 14
    // load issue together with ld_done keeps the count; flush during RAW stall
    tbl.push_back(mk(1, 0,0, 0,0, 13,1,1, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 15
    tbl.push_back(mk(1, 0,0, 0,0, 14,1,1, 0, 1,13, 0,0, 0,1,0, 32'h2000, 0)); // 16
    tbl.push_back(mk(1, 0,0, 0,0, 15,1,1, 0, 0,0,  0,0, 0,1,0, 32'h4000, 0)); // 17
    tbl.push_back(mk(1, 0,0, 0,0, 16,1,1, 0, 0,0,  0,0, 1,0,0, 32'hC000, 0)); // 18
    tbl.push_back(mk(1, 14,1,0,0, 17,1,0, 1, 0,0,  0,0, 0,0,0, 32'hC000, 0)); // 19
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,14, 0,0, 0,0,0, 32'hC000, 0)); // 20
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,15, 0,0, 0,0,0, 32'h8000, 0)); // 21
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    0)); // 22
    // mul x7 then div x8 waits for the unit
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 2, 0, 0,0,  0,0, 0,1,1, 32'h0,    0)); // 23
    tbl.push_back(mk(1, 0,0, 0,0, 8,1, 2, 0, 0,0,  0,0, 1,0,0, 32'h80,   0)); // 24
    tbl.push_back(mk(1, 0,0, 0,0, 8,1, 2, 0, 0,0,  1,7, 1,0,0, 32'h80,   0)); // 25
    tbl.push_back(mk(1, 0,0, 0,0, 8,1, 2, 0, 0,0,  0,0, 0,1,1, 32'h0,    0)); // 26
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h100,  0)); // 27
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  1,8, 0,0,0, 32'h100,  0)); // 28
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    0)); // 29
    // loads to x0 occupy slots but never mark busy
    tbl.push_back(mk(1, 0,0, 0,0, 0,1, 1, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 30
    tbl.push_back(mk(1, 0,1, 0,1, 0,1, 0, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 31
    tbl.push_back(mk(1, 0,0, 0,0, 0,1, 1, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 32
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 1, 0, 0,0,  0,0, 1,0,0, 32'h0,    0)); // 33
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,0,  0,0, 0,0,0, 32'h0,    0)); // 34
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,0,  0,0, 0,0,0, 32'h0,    0)); // 35
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 1, 0, 0,0,  0,0, 0,1,0, 32'h0,    0)); // 36
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,3,  0,0, 0,0,0, 32'h8,    0)); // 37
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    0)); // 38
    // md_done while idle raises a sticky error
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  1,9, 0,0,0, 32'h0,    0)); // 39
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    1)); // 40
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0,  0,0, 0,0,0, 32'h0,    1)); // 41

    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #2;
      chk_all(tbl[i], i);
    end

    // asynchronous reset in the middle of an outstanding load
    @(negedge clk);
    drive(mk(1,0,0,0,0,20,1,1,0,0,0,0,0, 0,1,0,32'h0,1));
    #2 chk_all(mk(1,0,0,0,0,20,1,1,0,0,0,0,0, 0,1,0,32'h0,1), 100);
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,32'h100000,1));
    #2 chk_all(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,32'h100000,1), 101);
    #1 rst_n = 1'b0;
    #1 chk_all(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,32'h0,0), 102);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1,0,0,0,0,21,1,1,0,0,0,0,0, 0,1,0,32'h0,0));
    #2 chk_all(mk(1,0,0,0,0,21,1,1,0,0,0,0,0, 0,1,0,32'h0,0), 103);
    @(negedge clk);
    drive(mk(1,0,0,0,0,22,1,1,0,0,0,0,0, 0,1,0,32'h200000,0));
    #2 chk_all(mk(1,0,0,0,0,22,1,1,0,0,0,0,0, 0,1,0,32'h200000,0), 104);
    @(negedge clk);
    drive(mk(1,0,0,0,0,23,1,1,0,0,0,0,0, 1,0,0,32'h600000,0));
    #2 chk_all(mk(1,0,0,0,0,23,1,1,0,0,0,0,0, 1,0,0,32'h600000,0), 105);

    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
